// File: rtl/dsp_mul_arbiter_if.sv
// Requester-side bundle of the shared multiplier: operand handshake
// and the result return path.
interface dsp_mul_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 36
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*DW-1:0] req_a;
    logic [NUM_REQ*DW-1:0] req_b;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [2*DW-1:0]       rsp_y;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_y
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_y
    );
endinterface

// File: rtl/dsp_mul_arbiter.sv
// Round-robin arbiter that shares one pipelined dsp multiplier between
// NUM_REQ requesters. A tag pipeline, matched to the multiplier depth,
// steers each product back to the requester that issued it.
module dsp_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 36,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    dsp_mul_arbiter_if.slave bus,
    output logic [DW-1:0]    mul_a,
    output logic [DW-1:0]    mul_b,
    input  logic [2*DW-1:0]  mul_y,
    output logic             idle,
    output logic [15:0]      op_cnt
);
    localparam int PW = $clog2(NUM_REQ);
    localparam logic [PW-1:0] LAST = PW'(NUM_REQ - 1);

    logic [PW-1:0]      ptr;
    logic [NUM_REQ-1:0] grant;
    logic [PW-1:0]      grant_idx;
    logic               accept;
    logic [LATENCY:0]   tag_vld_p;
    logic [PW-1:0]      tag_idx_p [LATENCY+1];
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [2*DW-1:0]    rsp_y_q;

    // Index base+off, wrapped into 0..NUM_REQ-1.
    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return PW'(sum);
    endfunction

    // Scan from ptr upward; scanning backwards lets the nearest valid win.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        if (en && rst) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (bus.req_valid[wrap_idx(ptr, k)]) begin
                    grant_idx = wrap_idx(ptr, k);
                end
            end
            grant[grant_idx] = bus.req_valid[grant_idx];
        end
    end

    assign accept        = |grant;
    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_y     = rsp_y_q;
    assign idle          = ~|tag_vld_p;

    // Issue stage: pointer advance, operand registers, tag valids, counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr       <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            tag_vld_p <= '0;
            op_cnt    <= '0;
        end else begin
            tag_vld_p <= {tag_vld_p[LATENCY-1:0], accept};
            if (accept) begin
                ptr   <= (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
                mul_a <= bus.req_a[int'(grant_idx)*DW +: DW];
                mul_b <= bus.req_b[int'(grant_idx)*DW +: DW];
                if (op_cnt != 16'hFFFF) op_cnt <= op_cnt + 16'd1;
            end
        end
    end

    // Requester index rides alongside the valid bits; only valid needs reset.
    always_ff @(posedge clk) begin
        tag_idx_p[0] <= grant_idx;
        for (int s = 1; s <= LATENCY; s++) begin
            tag_idx_p[s] <= tag_idx_p[s-1];
        end
    end

    // Response stage: capture the product and pulse the owner's valid bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid_q <= '0;
            rsp_y_q     <= '0;
        end else if (tag_vld_p[LATENCY]) begin
            rsp_valid_q <= NUM_REQ'(1) << tag_idx_p[LATENCY];
            rsp_y_q     <= mul_y;
        end else begin
            rsp_valid_q <= '0;
        end
    end
endmodule

// File: tb/tb_dsp_mul_arbiter.sv
// Bench for dsp_mul_arbiter: behavioural dsp multiplier, queue-based
// scoreboard of issued operations, directed scenarios plus a random run.
module tb_dsp_mul_arbiter;
    localparam int N   = 4;
    localparam int DW  = 36;
    localparam int LAT = 2;

    typedef struct {
        int          idx;
        logic [71:0] y;
        int          due;
    } op_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en  = 1'b0;
    logic [DW-1:0] mul_a;
    logic [DW-1:0] mul_b;
    logic [71:0]   mul_y;
    logic [71:0]   dsp_p1;
    logic          idle;
    logic [15:0]   op_cnt;

    dsp_mul_arbiter_if #(.NUM_REQ(N), .DW(DW)) bus ();

    dsp_mul_arbiter #(.NUM_REQ(N), .DW(DW), .LATENCY(LAT)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .bus   (bus),
        .mul_a (mul_a),
        .mul_b (mul_b),
        .mul_y (mul_y),
        .idle  (idle),
        .op_cnt(op_cnt)
    );

    always #5 clk = ~clk;

    // Two-stage unsigned multiplier standing in for the dsp block.
    always @(posedge clk) begin
        dsp_p1 <= 72'(mul_a) * 72'(mul_b);
        mul_y  <= dsp_p1;
    end

    op_t         q[$];
    int          m_ptr;
    logic [35:0] m_a, m_b;
    logic [71:0] m_y;
    int          m_cnt;
    int          edge_n;
    logic [35:0] a_in [N];
    logic [35:0] b_in [N];
    logic [N-1:0] last_rdy;
    int          checks;
    int          errors;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ptr = 0;
        m_a   = '0;
        m_b   = '0;
        m_y   = '0;
        m_cnt = 0;
    endtask

    // One clock: drive inputs at the falling edge, check the grant, then
    // check registered outputs at the next falling edge.
    task automatic cycle(input logic [N-1:0] vld, input logic e);
        int           g;
        logic [N-1:0] exp_rdy;
        op_t          o;
        bus.req_valid = vld;
        en = e;
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*DW +: DW] = a_in[i];
            bus.req_b[i*DW +: DW] = b_in[i];
        end
        #1;
        g = -1;
        if (e) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && vld[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        exp_rdy  = (g >= 0) ? (N'(1) << g) : '0;
        last_rdy = bus.req_ready;
        chk("req_ready", 72'(bus.req_ready), 72'(exp_rdy));
        if (g >= 0) begin
            o.idx = g;
            o.y   = 72'(a_in[g]) * 72'(b_in[g]);
            o.due = edge_n + 1 + LAT + 1;
            q.push_back(o);
            m_ptr = (g + 1) % N;
            m_a   = a_in[g];
            m_b   = b_in[g];
            if (m_cnt < 65535) m_cnt++;
        end
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        chk("mul_a", 72'(mul_a), 72'(m_a));
        chk("mul_b", 72'(mul_b), 72'(m_b));
        if (q.size() > 0 && q[0].due == edge_n) begin
            o   = q.pop_front();
            m_y = o.y;
            chk("rsp_valid", 72'(bus.rsp_valid), 72'(N'(1) << o.idx));
        end else begin
            chk("rsp_valid", 72'(bus.rsp_valid), 72'(0));
        end
        chk("rsp_y", bus.rsp_y, m_y);
        chk("idle", 72'(idle), 72'(q.size() == 0));
        chk("op_cnt", 72'(op_cnt), 72'(m_cnt));
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            a_in[i] = 36'({$urandom(), $urandom()});
            b_in[i] = 36'({$urandom(), $urandom()});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        edge_n = 0;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        for (int i = 0; i < N; i++) begin
            a_in[i] = '0;
            b_in[i] = '0;
        end
        model_reset();

        // Power-on reset.
        #1;
        chk("rst_rsp_valid", 72'(bus.rsp_valid), 72'(0));
        chk("rst_idle", 72'(idle), 72'(1));
        repeat (2) @(posedge clk);
        edge_n = 2;
        @(negedge clk);
        chk("rst_op_cnt", 72'(op_cnt), 72'(0));
        chk("rst_mul_a", 72'(mul_a), 72'(0));
        rst = 1'b1;

        // Single operation 3*5 from requester 0.
        a_in[0] = 36'd3;
        b_in[0] = 36'd5;
        cycle(4'b0001, 1'b1);
        repeat (3) cycle(4'b0000, 1'b1);
        chk("single_valid", 72'(bus.rsp_valid), 72'(4'b0001));
        chk("single_y", bus.rsp_y, 72'd15);
        chk("single_cnt", 72'(op_cnt), 72'(1));
        chk("single_idle", 72'(idle), 72'(1));

        // All requesters valid continuously: strict rotation from ptr=1.
        for (int i = 0; i < 8; i++) begin
            rand_ops();
            cycle(4'b1111, 1'b1);
            chk("rr_order", 72'(last_rdy), 72'(4'b0001 << ((1 + i) % 4)));
        end
        repeat (3) cycle(4'b0000, 1'b1);

        // Largest and zero products through requester 2.
        a_in[2] = 36'hFFFFFFFFF;
        b_in[2] = 36'hFFFFFFFFF;
        cycle(4'b0100, 1'b1);
        a_in[2] = 36'h0;
        cycle(4'b0100, 1'b1);
        repeat (2) cycle(4'b0000, 1'b1);
        chk("max_valid", 72'(bus.rsp_valid), 72'(4'b0100));
        chk("max_y", bus.rsp_y, 72'hFFFFFFFFE000000001);
        cycle(4'b0000, 1'b1);
        chk("zero_y", bus.rsp_y, 72'h0);

        // Pointer to 2, then requesters 1 and 3: 3 wins first, then 1.
        cycle(4'b0010, 1'b1);
        cycle(4'b1010, 1'b1);
        chk("rr_skip_3", 72'(last_rdy), 72'(4'b1000));
        cycle(4'b1010, 1'b1);
        chk("rr_skip_1", 72'(last_rdy), 72'(4'b0010));
        cycle(4'b1111, 1'b1);
        chk("rr_ptr_2", 72'(last_rdy), 72'(4'b0100));
        repeat (3) cycle(4'b0000, 1'b1);

        // Issue disabled right after an accept; the accepted op still returns.
        rand_ops();
        cycle(4'b1111, 1'b1);
        repeat (5) cycle(4'b1111, 1'b0);
        chk("en_idle", 72'(idle), 72'(1));

        // Reset with two operations in flight.
        rand_ops();
        cycle(4'b1111, 1'b1);
        rand_ops();
        cycle(4'b1111, 1'b1);
        rst = 1'b0;
        #1;
        model_reset();
        chk("arst_valid", 72'(bus.rsp_valid), 72'(0));
        chk("arst_y", bus.rsp_y, 72'(0));
        chk("arst_cnt", 72'(op_cnt), 72'(0));
        chk("arst_idle", 72'(idle), 72'(1));
        chk("arst_ready", 72'(bus.req_ready), 72'(0));
        chk("arst_mul_b", 72'(mul_b), 72'(0));
        repeat (2) begin
            @(posedge clk);
            edge_n++;
        end
        @(negedge clk);
        rst = 1'b1;

        // Random run of 200 accepted operations.
        for (int i = 0; i < 2000 && m_cnt < 200; i++) begin
            rand_ops();
            cycle(4'($urandom_range(1, 15)), ($urandom_range(0, 7) != 0));
        end
        chk("rand_count", 72'(op_cnt), 72'(200));
        repeat (4) cycle(4'b0000, 1'b1);
        chk("final_idle", 72'(idle), 72'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
